// File: rtl/time_of_day_counter.sv
// Time-of-day counter: prescaled hh:mm:ss with day count, load, alarm and
// 12/24-hour display. Strobes, alarm and load_err are registered pulses.
module time_of_day_counter #(
    parameter int TICKS_PER_SEC = 50,
    parameter int DAY_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             mode12,
    input  logic             load,
    input  logic [4:0]       ld_hr,
    input  logic [5:0]       ld_min,
    input  logic [5:0]       ld_sec,
    input  logic             alarm_en,
    input  logic [4:0]       alarm_hr,
    input  logic [5:0]       alarm_min,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hr,
    output logic [4:0]       hr_disp,
    output logic             pm,
    output logic [DAY_W-1:0] day,
    output logic             sec_tick,
    output logic             min_tick,
    output logic             hr_tick,
    output logic             day_tick,
    output logic             alarm,
    output logic             load_err
);

    localparam int PC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(TICKS_PER_SEC - 1);

    logic [PC_W-1:0]  pc;
    logic             adv;
    logic             ld_ok;
    logic             sec_wrap;
    logic             min_wrap;
    logic             hr_wrap;
    logic [5:0]       sec_nxt;
    logic [5:0]       min_nxt;
    logic [4:0]       hr_nxt;
    logic [DAY_W-1:0] day_nxt;
    logic             alarm_hit;

    assign adv   = run && (pc == PC_MAX);
    assign ld_ok = (ld_hr <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);

    assign sec_wrap = (sec == 6'd59);
    assign min_wrap = sec_wrap && (min == 6'd59);
    assign hr_wrap  = min_wrap && (hr == 5'd23);

    // Successor time; only committed on an advance edge.
    always_comb begin
        sec_nxt = sec_wrap ? 6'd0 : sec + 6'd1;
        min_nxt = min;
        hr_nxt  = hr;
        day_nxt = day;
        if (sec_wrap) begin
            min_nxt = (min == 6'd59) ? 6'd0 : min + 6'd1;
        end
        if (min_wrap) begin
            hr_nxt = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        end
        if (hr_wrap) begin
            day_nxt = day + 1'b1;
        end
    end

    // Out-of-range alarm settings cannot equal a legal successor time.
    assign alarm_hit = alarm_en && sec_wrap
                    && (hr_nxt == alarm_hr)
                    && (min_nxt == alarm_min);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= '0;
            sec      <= '0;
            min      <= '0;
            hr       <= '0;
            day      <= '0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            hr_tick  <= 1'b0;
            day_tick <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            hr_tick  <= 1'b0;
            day_tick <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
            if (load && ld_ok) begin
                // A valid load overrides any coinciding advance.
                pc  <= '0;
                sec <= ld_sec;
                min <= ld_min;
                hr  <= ld_hr;
            end else begin
                load_err <= load;
                if (adv) begin
                    pc       <= '0;
                    sec      <= sec_nxt;
                    min      <= min_nxt;
                    hr       <= hr_nxt;
                    day      <= day_nxt;
                    sec_tick <= 1'b1;
                    min_tick <= sec_wrap;
                    hr_tick  <= min_wrap;
                    day_tick <= hr_wrap;
                    alarm    <= alarm_hit;
                end else if (run) begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hr_disp = hr;
        if (mode12) begin
            if (hr == 5'd0) begin
                hr_disp = 5'd12;
            end else if (hr > 5'd12) begin
                hr_disp = hr - 5'd12;
            end
        end
    end

    assign pm = (hr >= 5'd12);

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with TICKS_PER_SEC=4: expected
// values are queued as stimulus is driven and popped when outputs are sampled.
module tb_time_of_day_counter;

    logic       clock;
    logic       reset_n;
    logic       run;
    logic       mode12;
    logic       load;
    logic [4:0] ld_hr;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic       alarm_en;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [4:0] hr_disp;
    logic       pm;
    logic [7:0] day;
    logic       sec_tick;
    logic       min_tick;
    logic       hr_tick;
    logic       day_tick;
    logic       alarm;
    logic       load_err;

    time_of_day_counter #(
        .TICKS_PER_SEC(4),
        .DAY_W(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .run(run),
        .mode12(mode12),
        .load(load),
        .ld_hr(ld_hr),
        .ld_min(ld_min),
        .ld_sec(ld_sec),
        .alarm_en(alarm_en),
        .alarm_hr(alarm_hr),
        .alarm_min(alarm_min),
        .sec(sec),
        .min(min),
        .hr(hr),
        .hr_disp(hr_disp),
        .pm(pm),
        .day(day),
        .sec_tick(sec_tick),
        .min_tick(min_tick),
        .hr_tick(hr_tick),
        .day_tick(day_tick),
        .alarm(alarm),
        .load_err(load_err)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        ld_hr  = 5'(h);
        ld_min = 6'(m);
        ld_sec = 6'(s);
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        run       = 1'b0;
        mode12    = 1'b1;
        load      = 1'b0;
        ld_hr     = '0;
        ld_min    = '0;
        ld_sec    = '0;
        alarm_en  = 1'b0;
        alarm_hr  = '0;
        alarm_min = '0;
        #2;

        // Reset state
        push("rst_sec", 0);
        push("rst_day", 0);
        push("rst_hr_disp12", 12);
        push("rst_pm", 0);
        push("rst_sec_tick", 0);
        pop_check(sec);
        pop_check(day);
        pop_check(hr_disp);
        pop_check(pm);
        pop_check(sec_tick);

        // T1: first second after 4 clocks, minute after 240
        run = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        push("t1_sec_at4", 1);
        push("t1_stick_at4", 1);
        tick(4);
        pop_check(sec);
        pop_check(sec_tick);
        cnt = 0;
        for (int i = 5; i <= 240; i++) begin
            tick(1);
            cnt += int'(sec_tick);
            if (i == 239) begin
                push("t1_sec_at239", 59);
                pop_check(sec);
            end
        end
        push("t1_stick_count", 59);
        push("t1_sec_at240", 0);
        push("t1_min_at240", 1);
        push("t1_mtick_at240", 1);
        pop_check(cnt);
        pop_check(sec);
        pop_check(min);
        pop_check(min_tick);

        // T2: day rollover with all strobes together
        do_load(23, 59, 58);
        push("t2_ld_hr", 23);
        push("t2_ld_sec", 58);
        push("t2_ld_stick", 0);
        pop_check(hr);
        pop_check(sec);
        pop_check(sec_tick);
        tick(4);
        push("t2_sec59", 59);
        pop_check(sec);
        tick(4);
        push("t2_hr", 0);
        push("t2_min", 0);
        push("t2_sec", 0);
        push("t2_day", 1);
        push("t2_ticks", 4'b1111);
        pop_check(hr);
        pop_check(min);
        pop_check(sec);
        pop_check(day);
        pop_check({sec_tick, min_tick, hr_tick, day_tick});

        // T3: 12-hour display
        mode12 = 1'b1;
        do_load(13, 5, 0);
        push("t3_disp12", 1);
        push("t3_pm", 1);
        push("t3_day_kept", 1);
        pop_check(hr_disp);
        pop_check(pm);
        pop_check(day);
        mode12 = 1'b0;
        #1;
        push("t3_disp24", 13);
        push("t3_hr", 13);
        pop_check(hr_disp);
        pop_check(hr);
        mode12 = 1'b1;
        do_load(0, 0, 0);
        push("t3_midnight_disp", 12);
        push("t3_midnight_pm", 0);
        pop_check(hr_disp);
        pop_check(pm);

        // T4: rejected loads, and a valid load on an advance edge
        do_load(10, 20, 30);
        do_load(24, 0, 0);
        push("t4_err_hr24", 1);
        push("t4_hr_kept", 10);
        push("t4_min_kept", 20);
        push("t4_sec_kept", 30);
        pop_check(load_err);
        pop_check(hr);
        pop_check(min);
        pop_check(sec);
        tick(1);
        push("t4_err_single", 0);
        pop_check(load_err);
        tick(1);
        do_load(10, 60, 0);
        push("t4_err_min60", 1);
        push("t4_adv_sec", 31);
        push("t4_adv_stick", 1);
        push("t4_adv_min", 20);
        pop_check(load_err);
        pop_check(sec);
        pop_check(sec_tick);
        pop_check(min);
        tick(3);
        do_load(5, 6, 7);
        push("t4_vld_hr", 5);
        push("t4_vld_min", 6);
        push("t4_vld_sec", 7);
        push("t4_vld_stick", 0);
        push("t4_vld_err", 0);
        pop_check(hr);
        pop_check(min);
        pop_check(sec);
        pop_check(sec_tick);
        pop_check(load_err);
        tick(3);
        push("t4_pc_restart_sec", 7);
        pop_check(sec);
        tick(1);
        push("t4_next_sec", 8);
        push("t4_next_stick", 1);
        pop_check(sec);
        pop_check(sec_tick);

        // T5: alarm
        alarm_hr  = 5'd7;
        alarm_min = 6'd30;
        alarm_en  = 1'b1;
        do_load(7, 29, 58);
        push("t5_ld_alarm", 0);
        pop_check(alarm);
        cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            cnt += int'(alarm);
            if (i == 8) begin
                push("t5_alarm_edge", 1);
                push("t5_min_at_alarm", 30);
                pop_check(alarm);
                pop_check(min);
            end
        end
        push("t5_alarm_count", 1);
        pop_check(cnt);
        alarm_en = 1'b0;
        do_load(7, 29, 58);
        cnt = 0;
        repeat (12) begin
            tick(1);
            cnt += int'(alarm);
        end
        push("t5_disabled_count", 0);
        push("t5_disabled_min", 30);
        pop_check(cnt);
        pop_check(min);
        alarm_en = 1'b1;
        do_load(7, 30, 0);
        cnt = int'(alarm);
        repeat (12) begin
            tick(1);
            cnt += int'(alarm);
        end
        push("t5_load_no_alarm", 0);
        pop_check(cnt);
        alarm_en = 1'b0;

        // T6: hold mid-second, load while held, then async reset
        do_load(1, 2, 3);
        tick(2);
        run = 1'b0;
        cnt = 0;
        repeat (100) begin
            tick(1);
            cnt += int'(sec_tick);
        end
        push("t6_hold_ticks", 0);
        push("t6_hold_sec", 3);
        pop_check(cnt);
        pop_check(sec);
        run = 1'b1;
        tick(1);
        push("t6_resume_sec", 3);
        push("t6_resume_stick", 0);
        pop_check(sec);
        pop_check(sec_tick);
        tick(1);
        push("t6_resume_adv", 4);
        push("t6_resume_adv_tick", 1);
        pop_check(sec);
        pop_check(sec_tick);

        run = 1'b0;
        do_load(2, 0, 0);
        push("t6_hold_load_hr", 2);
        pop_check(hr);
        run = 1'b1;
        tick(4);
        push("t6_pre_rst_stick", 1);
        push("t6_pre_rst_sec", 1);
        pop_check(sec_tick);
        pop_check(sec);

        mode12 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        push("t6_arst_sec", 0);
        push("t6_arst_hr", 0);
        push("t6_arst_day", 0);
        push("t6_arst_stick", 0);
        push("t6_arst_disp", 0);
        pop_check(sec);
        pop_check(hr);
        pop_check(day);
        pop_check(sec_tick);
        pop_check(hr_disp);
        #2;
        reset_n = 1'b1;
        tick(3);
        push("t6_restart_sec0", 0);
        pop_check(sec);
        tick(1);
        push("t6_restart_sec1", 1);
        pop_check(sec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
